lsu_ctrl: RTL and testbench

Load/store control stage that sits directly upstream of the `mem_read` / `mem_write` bus masters. It accepts one load or store request at a time from the pipeline's memory stage, checks alignment, and drives the read or write master's `en`/`addr`/`wdata`/`wmask` until that master reports completion. It then returns a sign- or zero-extended load result, or a store acknowledgement, as a one-cycle response. A timeout counter converts a hung bus access into an error response.

---
 rtl/lsu_ctrl.sv | 151 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store control stage: accepts one memory request, checks alignment, runs the
// read or write bus master until completion or timeout, then emits a one-cycle response.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mr_en,
    output logic [63:0] mr_addr,
    input  logic        mr_valid,
    input  logic [63:0] mr_rdata,
    output logic        mw_en,
    output logic [63:0] mw_addr,
    output logic [63:0] mw_wdata,
    output logic [3:0]  mw_wmask,
    input  logic        mw_finish
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    state_e      state;
    logic [1:0]  size_q;
    logic [2:0]  off_q;
    logic        uns_q;
    logic [31:0] cnt;

    logic        misaligned;
    logic [3:0]  wmask_dec;
    logic        timeout_hit;
    logic [63:0] lane;
    logic [63:0] load_ext;

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            2'd3:    misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign wmask_dec   = 4'b0001 << req_size;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TIMEOUT_CYCLES);
    assign lane        = mr_rdata >> {off_q, 3'b000};

    always_comb begin
        load_ext = lane;
        case (size_q)
            2'd0:    load_ext = uns_q ? {56'b0, lane[7:0]}  : {{56{lane[7]}}, lane[7:0]};
            2'd1:    load_ext = uns_q ? {48'b0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
            2'd2:    load_ext = uns_q ? {32'b0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
            default: load_ext = lane;
        endcase
    end

    // All outputs are registered; bus-side address/data are cleared whenever the enable drops.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= StIdle;
            size_q    <= '0;
            off_q     <= '0;
            uns_q     <= 1'b0;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mr_en     <= 1'b0;
            mr_addr   <= '0;
            mw_en     <= 1'b0;
            mw_addr   <= '0;
            mw_wdata  <= '0;
            mw_wmask  <= '0;
        end else begin
            case (state)
                StIdle: begin
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        size_q    <= req_size;
                        off_q     <= req_addr[2:0];
                        uns_q     <= req_unsigned;
                        cnt       <= '0;
                        if (misaligned) begin
                            state     <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else if (req_wen) begin
                            state    <= StWrite;
                            mw_en    <= 1'b1;
                            mw_addr  <= req_addr;
                            mw_wdata <= req_wdata;
                            mw_wmask <= wmask_dec;
                        end else begin
                            state   <= StRead;
                            mr_en   <= 1'b1;
                            mr_addr <= {req_addr[63:3], 3'b000};
                        end
                    end
                end
                StRead: begin
                    cnt <= cnt + 32'd1;
                    // Completion takes priority over a timeout in the same cycle.
                    if (mr_valid || timeout_hit) begin
                        state     <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_err   <= !mr_valid;
                        rsp_rdata <= mr_valid ? load_ext : 64'b0;
                        mr_en     <= 1'b0;
                        mr_addr   <= '0;
                    end
                end
                StWrite: begin
                    cnt <= cnt + 32'd1;
                    if (mw_finish || timeout_hit) begin
                        state     <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_err   <= !mw_finish;
                        rsp_rdata <= '0;
                        mw_en     <= 1'b0;
                        mw_addr   <= '0;
                        mw_wdata  <= '0;
                        mw_wmask  <= '0;
                    end
                end
                default: begin
                    state     <= StIdle;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: scenario tasks drive requests and bus responses;
// a response monitor pops expected results from a scoreboard queue.
module tb_lsu_ctrl;

    localparam int unsigned T = 4;
    localparam logic [63:0] D = 64'h0011_2233_8455_6677;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        mr_en;
    logic [63:0] mr_addr;
    logic        mr_valid = 1'b0;
    logic [63:0] mr_rdata = '0;
    logic        mw_en;
    logic [63:0] mw_addr;
    logic [63:0] mw_wdata;
    logic [3:0]  mw_wmask;
    logic        mw_finish = 1'b0;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    lsu_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .ACLK         (ACLK),
        .ARESETn      (ARESETn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wen      (req_wen),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mr_en        (mr_en),
        .mr_addr      (mr_addr),
        .mr_valid     (mr_valid),
        .mr_rdata     (mr_rdata),
        .mw_en        (mw_en),
        .mw_addr      (mw_addr),
        .mw_wdata     (mw_wdata),
        .mw_wmask     (mw_wmask),
        .mw_finish    (mw_finish)
    );

    always #5 ACLK = ~ACLK;

    // Response monitor: every rsp_valid must match the oldest expected response.
    always @(negedge ACLK) begin
        if (rsp_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rsp_unexpected: got rdata=%h err=%b, required no response",
                         rsp_rdata, rsp_err);
            end else begin
                mon_e = exp_q.pop_front();
                if (rsp_rdata !== mon_e.rdata || rsp_err !== mon_e.err) begin
                    n_bad++;
                    $display("FAIL rsp_data: got rdata=%h err=%b, required rdata=%h err=%b",
                             rsp_rdata, rsp_err, mon_e.rdata, mon_e.err);
                end
            end
        end
    end

    // Present a request and return at the negedge of the cycle after acceptance.
    task automatic send(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [1:0] size, input logic uns);
        bit done = 0;
        req_valid = 1'b1; req_wen = wen; req_addr = addr;
        req_wdata = wdata; req_size = size; req_unsigned = uns;
        for (int i = 0; i < 20 && !done; i++) begin
            if (req_ready === 1'b1) done = 1;
            @(negedge ACLK);
        end
        req_valid = 1'b0; req_wen = 1'b0; req_addr = '0;
        req_wdata = '0; req_size = '0; req_unsigned = 1'b0;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: got req_ready=%b, required 1 within 20 cycles", req_ready);
        end
    endtask

    // Aligned load whose read master answers in the first enabled cycle.
    task automatic load_1cyc(input logic [63:0] addr, input logic [1:0] size, input logic uns,
                             input logic [63:0] data, input logic [63:0] exp);
        logic [63:0] exp_addr;
        exp_addr = {addr[63:3], 3'b000};
        exp_q.push_back({exp, 1'b0});
        send(1'b0, addr, 64'h0, size, uns);
        n_cmp++;
        if (mr_en !== 1'b1 || mr_addr !== exp_addr || mw_en !== 1'b0) begin
            n_bad++;
            $display("FAIL load_bus: got mr_en=%b mr_addr=%h mw_en=%b, required 1 %h 0",
                     mr_en, mr_addr, mw_en, exp_addr);
        end
        mr_valid = 1'b1; mr_rdata = data;
        @(negedge ACLK);
        mr_valid = 1'b0; mr_rdata = '0;
        n_cmp++;
        if (rsp_valid !== 1'b1 || mr_en !== 1'b0 || mr_addr !== 64'h0 || req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL load_rsp_cycle: got rsp_valid=%b mr_en=%b mr_addr=%h req_ready=%b, required 1 0 0 0",
                     rsp_valid, mr_en, mr_addr, req_ready);
        end
        @(negedge ACLK);
        n_cmp++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL load_idle: got req_ready=%b rsp_valid=%b, required 1 0",
                     req_ready, rsp_valid);
        end
    endtask

    task automatic test_reset;
        @(negedge ACLK);
        n_cmp++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || mr_en !== 1'b0 ||
            mw_en !== 1'b0 || mr_addr !== 64'h0 || mw_addr !== 64'h0 || mw_wdata !== 64'h0 ||
            mw_wmask !== 4'h0 || rsp_rdata !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ready=%b rv=%b err=%b mr_en=%b mw_en=%b mask=%h, required all 0",
                     req_ready, rsp_valid, rsp_err, mr_en, mw_en, mw_wmask);
        end
        ARESETn = 1'b1;
        @(negedge ACLK);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got req_ready=%b, required 1", req_ready);
        end
    endtask

    task automatic test_back_to_back;
        load_1cyc(64'h8000_0003, 2'd0, 1'b0, D, 64'hFFFF_FFFF_FFFF_FF84);
        load_1cyc(64'h8000_0003, 2'd0, 1'b1, D, 64'h0000_0000_0000_0084);
    endtask

    task automatic test_load_sizes;
        load_1cyc(64'h8000_0004, 2'd2, 1'b0, D, 64'h0000_0000_0011_2233);
        load_1cyc(64'h8000_0002, 2'd1, 1'b0, D, 64'hFFFF_FFFF_FFFF_8455);
        load_1cyc(64'h8000_0002, 2'd1, 1'b1, D, 64'h0000_0000_0000_8455);
        load_1cyc(64'h8000_0000, 2'd2, 1'b0, D, 64'hFFFF_FFFF_8455_6677);
        load_1cyc(64'h8000_0000, 2'd3, 1'b1, D, D);
    endtask

    task automatic test_store;
        exp_q.push_back({64'h0, 1'b0});
        send(1'b1, 64'h8000_0008, 64'hDEAD_BEEF_CAFE_F00D, 2'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (mw_en !== 1'b1 || mw_wmask !== 4'b1000 || mw_addr !== 64'h8000_0008 ||
                mw_wdata !== 64'hDEAD_BEEF_CAFE_F00D || mr_en !== 1'b0 || rsp_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL store_bus: got mw_en=%b mask=%b addr=%h wdata=%h rv=%b, required 1 1000 8000_0008 deadbeefcafef00d 0",
                         mw_en, mw_wmask, mw_addr, mw_wdata, rsp_valid);
            end
            @(negedge ACLK);
        end
        mw_finish = 1'b1;
        @(negedge ACLK);
        mw_finish = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b1 || mw_en !== 1'b0 || mw_addr !== 64'h0 || mw_wdata !== 64'h0 ||
            mw_wmask !== 4'h0) begin
            n_bad++;
            $display("FAIL store_rsp: got rsp_valid=%b mw_en=%b addr=%h mask=%b, required 1 0 0 0",
                     rsp_valid, mw_en, mw_addr, mw_wmask);
        end
        @(negedge ACLK);
    endtask

    task automatic test_misaligned;
        logic [63:0] addrs [3] = '{64'h8000_0001, 64'h8000_0006, 64'h8000_0004};
        logic        wens  [3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  sizes [3] = '{2'd1, 2'd2, 2'd3};
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back({64'h0, 1'b1});
            send(wens[k], addrs[k], 64'h1234_5678, sizes[k], 1'b0);
            n_cmp++;
            if (rsp_valid !== 1'b1 || mr_en !== 1'b0 || mw_en !== 1'b0) begin
                n_bad++;
                $display("FAIL misaligned_%0d: got rsp_valid=%b mr_en=%b mw_en=%b, required 1 0 0",
                         k, rsp_valid, mr_en, mw_en);
            end
            @(negedge ACLK);
            n_cmp++;
            if (req_ready !== 1'b1 || mr_en !== 1'b0 || mw_en !== 1'b0) begin
                n_bad++;
                $display("FAIL misaligned_idle_%0d: got req_ready=%b mr_en=%b mw_en=%b, required 1 0 0",
                         k, req_ready, mr_en, mw_en);
            end
        end
    endtask

    task automatic test_timeout;
        int en_cycles = 0;
        bit got = 0;
        exp_q.push_back({64'h0, 1'b1});
        send(1'b0, 64'h8000_0000, 64'h0, 2'd3, 1'b0);
        for (int i = 0; i < 20 && !got; i++) begin
            if (rsp_valid === 1'b1) got = 1;
            else begin
                if (mr_en === 1'b1) en_cycles++;
                @(negedge ACLK);
            end
        end
        n_cmp++;
        if (!got || en_cycles != int'(T) + 1) begin
            n_bad++;
            $display("FAIL timeout_len: got rsp=%0d en_cycles=%0d, required rsp=1 en_cycles=%0d",
                     got, en_cycles, T + 1);
        end
        @(negedge ACLK);
        // Completion in the timeout cycle must win.
        exp_q.push_back({D, 1'b0});
        send(1'b0, 64'h8000_0000, 64'h0, 2'd3, 1'b0);
        repeat (T) @(negedge ACLK);
        n_cmp++;
        if (mr_en !== 1'b1 || rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_edge_en: got mr_en=%b rsp_valid=%b, required 1 0", mr_en, rsp_valid);
        end
        mr_valid = 1'b1; mr_rdata = D;
        @(negedge ACLK);
        mr_valid = 1'b0; mr_rdata = '0;
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_edge_rsp: got rsp_valid=%b, required 1", rsp_valid);
        end
        @(negedge ACLK);
    endtask

    task automatic test_reset_mid_write;
        send(1'b1, 64'h8000_0010, 64'h5555_AAAA_5555_AAAA, 2'd2, 1'b0);
        @(negedge ACLK);
        ARESETn = 1'b0;
        #1;
        n_cmp++;
        if (mw_en !== 1'b0 || mw_addr !== 64'h0 || mw_wdata !== 64'h0 || mw_wmask !== 4'h0 ||
            req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_write: got mw_en=%b addr=%h wdata=%h mask=%b ready=%b rv=%b, required all 0",
                     mw_en, mw_addr, mw_wdata, mw_wmask, req_ready, rsp_valid);
        end
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: got req_ready=%b, required 1", req_ready);
        end
        load_1cyc(64'h8000_0003, 2'd0, 1'b0, D, 64'hFFFF_FFFF_FFFF_FF84);
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_load_sizes;
        test_store;
        test_misaligned;
        test_timeout;
        test_reset_mid_write;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge ACLK);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL rsp_missing: got %0d outstanding responses, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
